// File: rtl/ipm_dl_pkg.sv
// Shared types and helpers for the distributed-RAM delay line.
package ipm_dl_pkg;

    // Controller states: filling the line, or streaming delayed samples.
    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } dl_state_e;

    // Width of depth requests and of the fill counter (holds up to 1024 plus one).
    localparam int CFG_W = 11;

    // ceil(log2(n)) with a floor of 4 address bits.
    function automatic int dl_addr_width(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 4) ? 4 : r;
    endfunction

endpackage

// File: rtl/ipm_distributed_sdpram_v1_2.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read.
// A read of the address being written returns the pre-write content.
module ipm_distributed_sdpram_v1_2 #(
    parameter int    ADDR_WIDTH = 4,
    parameter int    DATA_WIDTH = 16,
    parameter string INIT_FILE  = "NONE"
) (
    input  logic                  wr_clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    // This model carries no preload; reject any attempt to request one.
    generate
        if (INIT_FILE != "NONE") begin : g_init_check
            $error("ipm_distributed_sdpram_v1_2: preload files are not supported");
        end
    endgenerate

    // Write port: one word per enabled clock.
    always_ff @(posedge wr_clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/ipm_distributed_delayline_ctrl.sv
// Runtime-configurable delay line controller around one distributed SDP RAM.
// dout_valid rises once the line already holds `depth` samples, so every
// valid output is the sample accepted exactly `depth` accepts earlier.
module ipm_distributed_delayline_ctrl
    import ipm_dl_pkg::*;
#(
    parameter int MAX_DEPTH     = 16,
    parameter int DEFAULT_DEPTH = 16,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  asyn_rst,
    input  logic                  i_aclken,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  i_flush,
    input  logic                  cfg_valid,
    input  logic [CFG_W-1:0]      cfg_depth,
    output logic                  cfg_ready,
    output logic                  cfg_err,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic [CFG_W-1:0]      fill_level,
    output logic                  busy_fill
);

    localparam int AW = dl_addr_width(MAX_DEPTH);

    dl_state_e             state_q, state_d;
    logic [AW-1:0]         wr_addr_q, wr_addr_d;
    logic [CFG_W-1:0]      depth_q, depth_d;
    logic [CFG_W-1:0]      fill_q, fill_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_vld_q, dout_vld_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  rst_done_q;

    logic [AW-1:0]         rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  cfg_fire;
    logic                  cfg_ok;
    logic                  restart;
    logic [CFG_W-1:0]      fill_sat;

    // Read address trails the write address by depth; depth == 2**AW aliases
    // onto wr_addr and relies on the RAM returning pre-write data.
    assign rd_addr   = wr_addr_q - depth_q[AW-1:0];
    assign cfg_ready = rst_done_q && ((state_q == FILL) || (state_q == RUN));
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign cfg_ok    = (cfg_depth != '0) && (cfg_depth <= CFG_W'(MAX_DEPTH));
    assign restart   = (cfg_fire && cfg_ok) || i_flush;

    ipm_distributed_sdpram_v1_2 #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DATA_WIDTH),
        .INIT_FILE  ("NONE")
    ) u_ram (
        .wr_clk_i  (clk),
        .wr_en_i   (i_aclken),
        .wr_addr_i (wr_addr_q),
        .wr_data_i (din),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    // State, address, fill and output registers; all cleared asynchronously.
    always_ff @(posedge clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            state_q    <= FILL;
            wr_addr_q  <= '0;
            depth_q    <= CFG_W'(DEFAULT_DEPTH);
            fill_q     <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            depth_q    <= depth_d;
            fill_q     <= fill_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            cfg_err_q  <= cfg_err_d;
            rst_done_q <= 1'b1;
        end
    end

    // Next-state: accept/advance, then config errors, then refill overrides.
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        depth_d    = depth_q;
        fill_d     = fill_q;
        dout_d     = dout_q;
        dout_vld_d = dout_vld_q;
        cfg_err_d  = cfg_err_q;
        fill_sat   = (fill_q >= depth_q) ? depth_q : (fill_q + 1'b1);

        if (i_aclken) begin
            wr_addr_d  = wr_addr_q + 1'b1;
            dout_d     = rd_data;
            dout_vld_d = (fill_q >= depth_q);
            fill_d     = fill_sat;
            if ((state_q == FILL) && (fill_sat >= depth_q)) begin
                state_d = RUN;
            end
        end

        if (cfg_fire && !cfg_ok) begin
            cfg_err_d = 1'b1;
        end

        if (restart) begin
            if (cfg_fire && cfg_ok) begin
                depth_d = cfg_depth;
            end
            fill_d     = i_aclken ? CFG_W'(1) : '0;
            dout_vld_d = 1'b0;
            state_d    = FILL;
        end
    end

    assign cfg_err    = cfg_err_q;
    assign dout       = dout_q;
    assign dout_valid = dout_vld_q;
    assign fill_level = fill_q;
    assign busy_fill  = (state_q == FILL);

endmodule

// File: tb/tb_ipm_distributed_delayline_ctrl.sv
// Directed bench for the configurable delay line (default parameters).
module tb_ipm_distributed_delayline_ctrl;

    logic        clk;
    logic        asyn_rst;
    logic        i_aclken;
    logic [15:0] din;
    logic        i_flush;
    logic        cfg_valid;
    logic [10:0] cfg_depth;
    logic        cfg_ready;
    logic        cfg_err;
    logic [15:0] dout;
    logic        dout_valid;
    logic [10:0] fill_level;
    logic        busy_fill;

    int n_chk  = 0;
    int n_pass = 0;

    ipm_distributed_delayline_ctrl #(
        .MAX_DEPTH     (16),
        .DEFAULT_DEPTH (16),
        .DATA_WIDTH    (16)
    ) dut (
        .clk        (clk),
        .asyn_rst   (asyn_rst),
        .i_aclken   (i_aclken),
        .din        (din),
        .i_flush    (i_flush),
        .cfg_valid  (cfg_valid),
        .cfg_depth  (cfg_depth),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .dout       (dout),
        .dout_valid (dout_valid),
        .fill_level (fill_level),
        .busy_fill  (busy_fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_chk++;
        assert (obs === 32'(exp)) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        asyn_rst  = 1'b1;
        i_aclken  = 1'b0;
        din       = '0;
        i_flush   = 1'b0;
        cfg_valid = 1'b0;
        cfg_depth = '0;
        #3;
        chk("rst_dout", 32'(dout), 0);
        chk("rst_valid", 32'(dout_valid), 0);
        chk("rst_ready", 32'(cfg_ready), 0);
        chk("rst_err", 32'(cfg_err), 0);
        chk("rst_fill", 32'(fill_level), 0);
        chk("rst_busy", 32'(busy_fill), 1);
        tick();
        asyn_rst = 1'b0;
        #1;
        chk("ready_first_cycle", 32'(cfg_ready), 0);
        tick();
        chk("ready_after", 32'(cfg_ready), 1);

        // Default depth 16, continuous stream, wraps the 16-entry RAM three times.
        i_aclken = 1'b1;
        for (int k = 1; k <= 52; k++) begin
            din = 16'(k);
            tick();
            chk("t1_fill", 32'(fill_level), (k < 16) ? k : 16);
            chk("t1_busy", 32'(busy_fill), (k < 16) ? 1 : 0);
            chk("t1_valid", 32'(dout_valid), (k >= 17) ? 1 : 0);
            if (k >= 17) chk("t1_dout", 32'(dout), k - 16);
        end

        // Out-of-range depths: handshake completes, error sticks, delay stays 16.
        cfg_valid = 1'b1;
        cfg_depth = 11'd0;
        din = 16'd53;
        tick();
        chk("t3_err0", 32'(cfg_err), 1);
        chk("t3_valid0", 32'(dout_valid), 1);
        chk("t3_dout0", 32'(dout), 37);
        chk("t3_fill0", 32'(fill_level), 16);
        cfg_depth = 11'd2000;
        din = 16'd54;
        tick();
        chk("t3_err1", 32'(cfg_err), 1);
        chk("t3_dout1", 32'(dout), 38);
        chk("t3_busy1", 32'(busy_fill), 0);
        cfg_valid = 1'b0;
        for (int k = 55; k <= 58; k++) begin
            din = 16'(k);
            tick();
            chk("t3_err_hold", 32'(cfg_err), 1);
            chk("t3_valid_hold", 32'(dout_valid), 1);
            chk("t3_dout_hold", 32'(dout), k - 16);
        end

        // Retune to depth 5 mid-stream with a sample in the same cycle.
        cfg_valid = 1'b1;
        cfg_depth = 11'd5;
        din = 16'd59;
        tick();
        chk("t2_valid_drop", 32'(dout_valid), 0);
        chk("t2_fill_cfg", 32'(fill_level), 1);
        chk("t2_busy_cfg", 32'(busy_fill), 1);
        cfg_valid = 1'b0;
        for (int k = 60; k <= 70; k++) begin
            din = 16'(k);
            tick();
            chk("t2_fill", 32'(fill_level), (k - 58 < 5) ? (k - 58) : 5);
            chk("t2_busy", 32'(busy_fill), (k < 63) ? 1 : 0);
            chk("t2_valid", 32'(dout_valid), (k >= 64) ? 1 : 0);
            if (k >= 64) chk("t2_dout", 32'(dout), k - 5);
        end

        // Depth 4 with one accept every third cycle; outputs hold while idle.
        i_aclken = 1'b0;
        cfg_valid = 1'b1;
        cfg_depth = 11'd4;
        tick();
        chk("t5_fill_cfg", 32'(fill_level), 0);
        chk("t5_valid_cfg", 32'(dout_valid), 0);
        cfg_valid = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            i_aclken = 1'b1;
            din = 16'(100 + j);
            tick();
            chk("t5_fill", 32'(fill_level), (j < 4) ? j : 4);
            chk("t5_valid", 32'(dout_valid), (j >= 5) ? 1 : 0);
            if (j >= 5) chk("t5_dout", 32'(dout), 96 + j);
            i_aclken = 1'b0;
            din = 16'hdead;
            for (int g = 0; g < 2; g++) begin
                tick();
                chk("t5_fill_hold", 32'(fill_level), (j < 4) ? j : 4);
                chk("t5_valid_hold", 32'(dout_valid), (j >= 5) ? 1 : 0);
                if (j >= 5) chk("t5_dout_hold", 32'(dout), 96 + j);
            end
        end

        // Flush plus depth-3 config plus a sample in the same cycle.
        i_aclken = 1'b1;
        i_flush = 1'b1;
        cfg_valid = 1'b1;
        cfg_depth = 11'd3;
        din = 16'd200;
        tick();
        chk("t6_fill", 32'(fill_level), 1);
        chk("t6_busy", 32'(busy_fill), 1);
        chk("t6_valid", 32'(dout_valid), 0);
        i_flush = 1'b0;
        cfg_valid = 1'b0;
        din = 16'd201;
        tick();
        din = 16'd202;
        tick();
        chk("t6_busy_run", 32'(busy_fill), 0);
        chk("t6_valid_pre", 32'(dout_valid), 0);
        din = 16'd203;
        tick();
        chk("t6_valid_run", 32'(dout_valid), 1);
        chk("t6_dout_run", 32'(dout), 200);
        chk("t6_err_sticky", 32'(cfg_err), 1);

        // Asynchronous reset mid-run, checked between clock edges.
        asyn_rst = 1'b1;
        #1;
        chk("ar_dout", 32'(dout), 0);
        chk("ar_valid", 32'(dout_valid), 0);
        chk("ar_fill", 32'(fill_level), 0);
        chk("ar_ready", 32'(cfg_ready), 0);
        chk("ar_err", 32'(cfg_err), 0);
        chk("ar_busy", 32'(busy_fill), 1);
        tick();
        asyn_rst = 1'b0;
        i_aclken = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
